// File: rtl/loop_gain_scheduler_if.sv
// Phase-detector input and gain-schedule output bundle for loop_gain_scheduler.
interface loop_gain_scheduler_if;
    logic               enable;
    logic signed [31:0] pd;
    logic               pd_valid;
    logic [4:0]         c1_shift;
    logic [4:0]         c2_shift;
    logic               clear_int;
    logic               lock;
    logic [1:0]         state;
    logic [31:0]        metric;
    logic               win_done;

    modport master (
        output enable, pd, pd_valid,
        input  c1_shift, c2_shift, clear_int, lock, state, metric, win_done
    );

    modport slave (
        input  enable, pd, pd_valid,
        output c1_shift, c2_shift, clear_int, lock, state, metric, win_done
    );
endinterface

// File: rtl/loop_gain_scheduler.sv
// Carrier-loop gain scheduler: windowed mean |pd| lock detector driving
// acquisition/tracking loop-filter shifts.
module loop_gain_scheduler #(
    parameter int          WIN_LOG2   = 8,
    parameter logic [31:0] LOCK_THR   = 32'd4096,
    parameter logic [31:0] UNLOCK_THR = 32'd16384,
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 2,
    parameter int          ACQ_C1     = 2,
    parameter int          ACQ_C2     = 10,
    parameter int          TRK_C1     = 4,
    parameter int          TRK_C2     = 14
) (
    input logic                   clk,
    input logic                   rst,
    loop_gain_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, TRACK = 2'b10} state_t;

    localparam int MAXC = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = 32 + WIN_LOG2;

    state_t                state_q, state_d;
    logic [CW-1:0]         good_q, good_d, bad_q, bad_d;
    logic [4:0]            c1_q, c2_q;
    logic                  clear_q, lock_q;
    logic [AW-1:0]         acc_q, acc_sum;
    logic [WIN_LOG2-1:0]   cnt_q;
    logic [31:0]           metric_q, pd_neg, pd_mag;
    logic                  win_done_q, running, last;

    // -2^31 has no positive counterpart; clamp it to the largest magnitude
    assign pd_neg  = 32'(-bus.pd);
    assign pd_mag  = bus.pd[31] ? ((bus.pd[30:0] == '0) ? 32'h7fff_ffff : pd_neg) : bus.pd;
    assign acc_sum = acc_q + AW'(pd_mag);
    assign running = (state_q != IDLE) && bus.enable;
    assign last    = running && bus.pd_valid && (cnt_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            metric_q   <= '0;
            win_done_q <= 1'b0;
        end else begin
            win_done_q <= last;
            if (!running) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (bus.pd_valid) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    acc_q    <= '0;
                    metric_q <= 32'(acc_sum >> WIN_LOG2);
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    // Window verdicts act on the metric registered in the win_done cycle
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (!bus.enable) begin
            state_d = IDLE;
            good_d  = '0;
            bad_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ACQ;
                ACQ: if (win_done_q) begin
                    if (metric_q < LOCK_THR) begin
                        if (good_q == CW'(LOCK_CNT - 1)) begin
                            state_d = TRACK;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                TRACK: if (win_done_q) begin
                    if (metric_q > UNLOCK_THR) begin
                        if (bad_q == CW'(UNLOCK_CNT - 1)) begin
                            state_d = ACQ;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Mode outputs are registered from the next state so they switch with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            good_q  <= '0;
            bad_q   <= '0;
            c1_q    <= 5'(ACQ_C1);
            c2_q    <= 5'(ACQ_C2);
            clear_q <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            c1_q    <= (state_d == TRACK) ? 5'(TRK_C1) : 5'(ACQ_C1);
            c2_q    <= (state_d == TRACK) ? 5'(TRK_C2) : 5'(ACQ_C2);
            clear_q <= (state_d == IDLE);
            lock_q  <= (state_d == TRACK);
        end
    end

    assign bus.state     = state_q;
    assign bus.c1_shift  = c1_q;
    assign bus.c2_shift  = c2_q;
    assign bus.clear_int = clear_q;
    assign bus.lock      = lock_q;
    assign bus.metric    = metric_q;
    assign bus.win_done  = win_done_q;
endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Randomized window-level bench for loop_gain_scheduler (WIN_LOG2=2, other defaults).
module tb_loop_gain_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    loop_gain_scheduler_if bus();
    loop_gain_scheduler #(.WIN_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    // reference lock model: 0 IDLE, 1 ACQ, 2 TRACK
    int m_state = 0;
    int m_good  = 0;
    int m_bad   = 0;

    function automatic longint mag(input int v);
        longint a = longint'(v);
        if (a < 0) a = -a;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        return a;
    endfunction

    // sample classes: 0 small, 1 large, 2 any, 3 =4096, 4 =16384, 5 mid,
    // 6 most negative, 7 +-1000, 8 +20000, 9 +-100
    function automatic int gen(input int cls);
        int m;
        case (cls)
            0: m = int'($urandom_range(0, 4000));
            1: m = int'($urandom_range(17000, 40000));
            2: return int'($urandom);
            3: m = 4096;
            4: m = 16384;
            6: return int'(32'h8000_0000);
            7: m = 1000;
            8: return 20000;
            9: m = 100;
            default: m = int'($urandom_range(0, 20000));
        endcase
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    function automatic void model_eval(input longint met);
        if (m_state == 1) begin
            if (met < 4096) begin
                m_good++;
                if (m_good == 4) begin m_state = 2; m_good = 0; m_bad = 0; end
            end else m_good = 0;
        end else if (m_state == 2) begin
            if (met > 16384) begin
                m_bad++;
                if (m_bad == 2) begin m_state = 1; m_good = 0; m_bad = 0; end
            end else m_bad = 0;
        end
    endfunction

    // one window of four samples with random idle gaps, then the verdict cycle
    task automatic do_window(input int cls, input int maxgap, input string tag);
        longint sum = 0;
        logic [31:0] exp_m;
        logic [1:0] exp_st;
        int v;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                bus.pd = int'($urandom); bus.pd_valid = 1'b0;
                @(negedge clk);
                checks++;
                if (bus.win_done !== 1'b0) begin
                    failures++; $display("FAIL %s gap win_done got %b want 0", tag, bus.win_done);
                end
            end
            v = gen(cls);
            bus.pd = v; bus.pd_valid = 1'b1;
            sum += mag(v);
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (bus.win_done !== 1'b0) begin
                    failures++; $display("FAIL %s early win_done at sample %0d", tag, i);
                end
            end
        end
        bus.pd_valid = 1'b0;
        exp_m = 32'(sum >> 2);
        checks++;
        if (bus.win_done !== 1'b1) begin
            failures++; $display("FAIL %s win_done got %b want 1", tag, bus.win_done);
        end
        checks++;
        if (bus.metric !== exp_m) begin
            failures++; $display("FAIL %s metric got %0d want %0d", tag, bus.metric, exp_m);
        end
        model_eval(sum >> 2);
        exp_st = 2'(m_state);
        @(negedge clk);
        checks++;
        if (bus.state !== exp_st || bus.lock !== (m_state == 2) || bus.win_done !== 1'b0) begin
            failures++;
            $display("FAIL %s verdict state/lock/win_done got %b/%b/%b want %b/%b/0",
                     tag, bus.state, bus.lock, bus.win_done, exp_st, (m_state == 2));
        end
        checks++;
        if (bus.c1_shift !== ((m_state == 2) ? 5'd4 : 5'd2) ||
            bus.c2_shift !== ((m_state == 2) ? 5'd14 : 5'd10) || bus.clear_int !== 1'b0) begin
            failures++;
            $display("FAIL %s shifts c1/c2/clr got %0d/%0d/%b state %0d", tag,
                     bus.c1_shift, bus.c2_shift, bus.clear_int, m_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.enable = 1'b1; bus.pd_valid = 1'b1; bus.pd = 32'sd5000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.state !== 2'b00 || bus.c1_shift !== 5'd2 || bus.c2_shift !== 5'd10) begin
            failures++; $display("FAIL reset state/c1/c2 got %b/%0d/%0d want 00/2/10",
                                 bus.state, bus.c1_shift, bus.c2_shift);
        end
        checks++;
        if (bus.clear_int !== 1'b1 || bus.lock !== 1'b0 || bus.metric !== 32'd0 || bus.win_done !== 1'b0) begin
            failures++; $display("FAIL reset clr/lock/metric/wd got %b/%b/%0d/%b want 1/0/0/0",
                                 bus.clear_int, bus.lock, bus.metric, bus.win_done);
        end
        rst = 1'b0; bus.pd_valid = 1'b0;
        @(negedge clk);
        m_state = 1; m_good = 0; m_bad = 0;
        checks++;
        if (bus.state !== 2'b01 || bus.clear_int !== 1'b0) begin
            failures++; $display("FAIL reset_exit state/clr got %b/%b want 01/0", bus.state, bus.clear_int);
        end
    endtask

    task automatic test_acq_lock();
        for (int w = 0; w < 4; w++) do_window(7, 2, "acq_lock");
        checks++;
        if (bus.state !== 2'b10 || bus.lock !== 1'b1 || bus.c1_shift !== 5'd4 || bus.c2_shift !== 5'd14) begin
            failures++; $display("FAIL acq_lock final state/lock/c1/c2 got %b/%b/%0d/%0d want 10/1/4/14",
                                 bus.state, bus.lock, bus.c1_shift, bus.c2_shift);
        end
    endtask

    task automatic test_loss_of_lock();
        for (int w = 0; w < 2; w++) do_window(8, 1, "loss_of_lock");
        checks++;
        if (bus.state !== 2'b01 || bus.lock !== 1'b0 || bus.c1_shift !== 5'd2) begin
            failures++; $display("FAIL loss_of_lock state/lock/c1 got %b/%b/%0d want 01/0/2",
                                 bus.state, bus.lock, bus.c1_shift);
        end
    endtask

    task automatic test_saturation();
        for (int w = 0; w < 3; w++) do_window(9, 1, "sat_pre");
        do_window(6, 1, "sat_window");
        for (int w = 0; w < 3; w++) do_window(9, 1, "sat_post");
        checks++;
        if (bus.state !== 2'b01) begin
            failures++; $display("FAIL sat_good_cleared state got %b want 01", bus.state);
        end
        do_window(9, 1, "sat_lock");
    endtask

    task automatic test_boundaries();
        do_window(8, 1, "bnd_bad1");
        do_window(4, 1, "bnd_16384");
        do_window(8, 1, "bnd_bad2");
        checks++;
        if (bus.state !== 2'b10) begin
            failures++; $display("FAIL bnd_bad_cleared state got %b want 10", bus.state);
        end
        do_window(8, 1, "bnd_unlock");
        for (int w = 0; w < 3; w++) do_window(0, 1, "bnd_good");
        do_window(3, 1, "bnd_4096");
        for (int w = 0; w < 3; w++) do_window(0, 1, "bnd_good2");
        checks++;
        if (bus.state !== 2'b01) begin
            failures++; $display("FAIL bnd_good_cleared state got %b want 01", bus.state);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) begin
            bus.pd = gen(0); bus.pd_valid = 1'b1; @(negedge clk);
        end
        bus.pd = gen(0); bus.enable = 1'b0;
        @(negedge clk);
        bus.pd_valid = 1'b0;
        m_state = 0; m_good = 0; m_bad = 0;
        checks++;
        if (bus.win_done !== 1'b0 || bus.state !== 2'b00 || bus.clear_int !== 1'b1 || bus.lock !== 1'b0) begin
            failures++; $display("FAIL abort wd/state/clr/lock got %b/%b/%b/%b want 0/00/1/0",
                                 bus.win_done, bus.state, bus.clear_int, bus.lock);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        m_state = 1;
        checks++;
        if (bus.state !== 2'b01) begin
            failures++; $display("FAIL abort_resume state got %b want 01", bus.state);
        end
        for (int w = 0; w < 4; w++) do_window(0, 0, "abort_relock");
        bus.enable = 1'b0;
        @(negedge clk);
        m_state = 0; m_good = 0; m_bad = 0;
        checks++;
        if (bus.lock !== 1'b0 || bus.c1_shift !== 5'd2 || bus.c2_shift !== 5'd10 || bus.state !== 2'b00) begin
            failures++; $display("FAIL abort_track lock/c1/c2/state got %b/%0d/%0d/%b want 0/2/10/00",
                                 bus.lock, bus.c1_shift, bus.c2_shift, bus.state);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        m_state = 1;
    endtask

    task automatic test_random();
        for (int w = 0; w < 24; w++) do_window(int'($urandom_range(0, 5)), 3, "random");
    endtask

    // continuous valid samples: windows abut with no idle cycles between them
    task automatic test_back_to_back();
        longint sum = 0;
        logic [31:0] exp_m;
        int v;
        int cls;
        cls = int'($urandom_range(0, 5));
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0) cls = int'($urandom_range(0, 5));
            v = gen(cls);
            bus.pd = v; bus.pd_valid = 1'b1;
            sum += mag(v);
            @(negedge clk);
            if (k > 0 && k % 4 == 0) begin
                checks++;
                if (bus.state !== 2'(m_state) || bus.lock !== (m_state == 2)) begin
                    failures++; $display("FAIL b2b verdict k=%0d state/lock got %b/%b want %0d",
                                         k, bus.state, bus.lock, m_state);
                end
            end
            checks++;
            if (bus.win_done !== (k % 4 == 3)) begin
                failures++; $display("FAIL b2b win_done k=%0d got %b", k, bus.win_done);
            end
            if (k % 4 == 3) begin
                exp_m = 32'(sum >> 2);
                checks++;
                if (bus.metric !== exp_m) begin
                    failures++; $display("FAIL b2b metric got %0d want %0d", bus.metric, exp_m);
                end
                model_eval(sum >> 2);
                sum = 0;
            end
        end
        bus.pd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'(m_state) || bus.win_done !== 1'b0) begin
            failures++; $display("FAIL b2b final state/wd got %b/%b want %0d/0", bus.state, bus.win_done, m_state);
        end
    endtask

    initial begin
        bus.enable = 1'b0; bus.pd = '0; bus.pd_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_acq_lock();
        test_loss_of_lock();
        test_saturation();
        test_boundaries();
        test_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
